// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with the instruction cache,
// buffers one word across downstream stalls and applies downstream redirects.
//
// state   | meaning
// FETCH   | requesting imemaddr from the cache, forwarding hits to IF/ID
// HOLD    | hit captured while IF/ID stalled; waiting to release it
// HALTED  | halt word delivered; idle until redirect or reset
module fetch_unit #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imemload_in,
    output logic [31:0] pcp4_in,
    output logic        if_id_wen,
    output logic        flush
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic [31:0] hold_pcp4, hold_pcp4_nxt;
    logic [31:0] pc_p4;

    assign pc_p4    = pc + 32'd4;
    assign imemaddr = pc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= FETCH;
            pc         <= PC_INIT;
            hold_instr <= '0;
            hold_pcp4  <= '0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            hold_instr <= hold_instr_nxt;
            hold_pcp4  <= hold_pcp4_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        hold_instr_nxt = hold_instr;
        hold_pcp4_nxt  = hold_pcp4;
        imemREN        = 1'b0;
        imemload_in    = '0;
        pcp4_in        = '0;
        if_id_wen      = 1'b0;
        flush          = 1'b0;

        // Reset forces quiet outputs even before the asynchronous clear settles.
        if (!RST) begin
            imemREN = (state == FETCH);
            if (redirect) begin
                flush          = 1'b1;
                pc_nxt         = {redirect_pc[31:2], 2'b00};
                hold_instr_nxt = '0;
                hold_pcp4_nxt  = '0;
                state_nxt      = FETCH;
            end else begin
                unique case (state)
                    FETCH: begin
                        if (ihit) begin
                            pc_nxt = pc_p4;
                            if (stall) begin
                                hold_instr_nxt = iload;
                                hold_pcp4_nxt  = pc_p4;
                                state_nxt      = HOLD;
                            end else begin
                                imemload_in = iload;
                                pcp4_in     = pc_p4;
                                if_id_wen   = 1'b1;
                                if (iload == HALT_WORD)
                                    state_nxt = HALTED;
                            end
                        end
                    end
                    HOLD: begin
                        if (!stall) begin
                            imemload_in = hold_instr;
                            pcp4_in     = hold_pcp4;
                            if_id_wen   = 1'b1;
                            state_nxt   = (hold_instr == HALT_WORD) ? HALTED : FETCH;
                        end
                    end
                    HALTED: begin
                    end
                    default: state_nxt = FETCH;
                endcase
            end
        end
    end

endmodule
